// File: rtl/bitwise_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bitwise_op_scheduler
// Description : Two-requester round-robin scheduler for a single bitwise ALU.
//               IDLE grants one requester, EXEC computes the result, RESP
//               holds it until the consumer accepts it.
// Revision    : 1.0 - initial release
// ============================================================================
module bitwise_op_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] c_OP_AND  = 3'd0;
  localparam logic [2:0] c_OP_OR   = 3'd1;
  localparam logic [2:0] c_OP_NAND = 3'd2;
  localparam logic [2:0] c_OP_NOR  = 3'd3;
  localparam logic [2:0] c_OP_XOR  = 3'd4;
  localparam logic [2:0] c_OP_XNOR = 3'd5;

  state_t             state_q, state_d;
  logic               last_grant_q;   // 1 = requester 1 was granted last
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2:0]         op_q;
  logic               id_q;
  logic [WIDTH-1:0]   result_q;
  logic               rsp_id_q;
  logic               err_q;
  logic [7:0]         count_q;

  logic               w_grant0, w_grant1, w_hs;
  logic [WIDTH-1:0]   w_result;
  logic               w_err;

  // Round-robin grant: only in IDLE, only to a valid requester, never both.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (state_q == S_IDLE) begin
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        w_grant0 = 1'b1;
      end else if (req1_valid) begin
        w_grant1 = 1'b1;
      end
    end
  end

  assign w_hs       = w_grant0 | w_grant1;
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Next-state logic for the IDLE -> EXEC -> RESP cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_hs) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the granted requester's operands and remember who won.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 3'd0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (w_hs) begin
      a_q          <= w_grant1 ? req1_a  : req0_a;
      b_q          <= w_grant1 ? req1_b  : req0_b;
      op_q         <= w_grant1 ? req1_op : req0_op;
      id_q         <= w_grant1;
      last_grant_q <= w_grant1;
    end
  end

  // Bitwise ALU over the latched operands; opcodes 6 and 7 are illegal.
  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    case (op_q)
      c_OP_AND:  w_result = a_q & b_q;
      c_OP_OR:   w_result = a_q | b_q;
      c_OP_NAND: w_result = ~(a_q & b_q);
      c_OP_NOR:  w_result = ~(a_q | b_q);
      c_OP_XOR:  w_result = a_q ^ b_q;
      c_OP_XNOR: w_result = ~(a_q ^ b_q);
      default:   w_err    = 1'b1;
    endcase
  end

  // Response registers load only on leaving EXEC so they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      rsp_id_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (state_q == S_EXEC) begin
      result_q <= w_result;
      rsp_id_q <= id_q;
      err_q    <= w_err;
    end
  end

  // Completed-response counter, wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else if ((state_q == S_RESP) && rsp_ready) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_result = result_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = err_q;
  assign op_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitwise_op_scheduler
// Description : Directed, table-driven self-checking bench for the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitwise_op_scheduler;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_a, req0_b;
  logic [2:0] req0_op;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_a, req1_b;
  logic [2:0] req1_op;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_id, rsp_err;
  logic [7:0] op_count;

  int         checks;
  int         failures;
  logic [7:0] exp_cnt;

  typedef struct {
    int         rq;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
    logic       err;
  } vec_t;

  vec_t vecs[10];

  bitwise_op_scheduler #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so a stuck design still ends the run.
  initial begin
    #1000000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Bitwise reference: returns {err, result}.
  function automatic logic [4:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'd0:    ref_op = {1'b0, a & b};
      3'd1:    ref_op = {1'b0, a | b};
      3'd2:    ref_op = {1'b0, ~(a & b)};
      3'd3:    ref_op = {1'b0, ~(a | b)};
      3'd4:    ref_op = {1'b0, a ^ b};
      3'd5:    ref_op = {1'b0, ~(a ^ b)};
      default: ref_op = {1'b1, 4'h0};
    endcase
  endfunction

  // One full operation from a single requester with rsp_ready held high.
  task automatic run_op(input int rq, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input logic [3:0] exp_res, input logic exp_err);
    bit got;
    got = 1'b0;
    rsp_ready = 1'b1;
    if (rq == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if ((rq == 0 && req0_ready) || (rq == 1 && req1_ready)) got = 1'b1;
      else @(negedge clk);
    end
    check("grant", {31'd0, got}, 32'd1);
    if (got) begin
      @(posedge clk); #1;
      // Scramble the inputs while the operation is in flight.
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = ~a; req0_b = ~b; req0_op = op + 3'd1;
      req1_a = ~a; req1_b = ~b; req1_op = op + 3'd1;
      check("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
      check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("rsp_result", {28'd0, rsp_result}, {28'd0, exp_res});
      check("rsp_id", {31'd0, rsp_id}, rq[31:0]);
      check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 8'd1;
      check("op_count", {24'd0, op_count}, {24'd0, exp_cnt});
      check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("held_result", {28'd0, rsp_result}, {28'd0, exp_res});
    end else begin
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
  endtask

  initial begin
    bit         found;
    logic [4:0] r;
    checks = 0; failures = 0; exp_cnt = 8'd0;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = 4'h0; req0_b = 4'h0; req0_op = 3'd0;
    req1_valid = 1'b0; req1_a = 4'h0; req1_b = 4'h0; req1_op = 3'd0;

    vecs[0] = '{0, 4'hC, 4'hA, 3'd0, 4'h8, 1'b0};
    vecs[1] = '{1, 4'hC, 4'hA, 3'd1, 4'hE, 1'b0};
    vecs[2] = '{0, 4'hC, 4'hA, 3'd2, 4'h7, 1'b0};
    vecs[3] = '{1, 4'hC, 4'hA, 3'd3, 4'h1, 1'b0};
    vecs[4] = '{0, 4'hC, 4'hA, 3'd4, 4'h6, 1'b0};
    vecs[5] = '{1, 4'hC, 4'hA, 3'd5, 4'h9, 1'b0};
    vecs[6] = '{0, 4'hF, 4'hF, 3'd7, 4'h0, 1'b1};
    vecs[7] = '{1, 4'h5, 4'h3, 3'd6, 4'h0, 1'b1};
    vecs[8] = '{0, 4'h5, 4'h3, 3'd4, 4'h6, 1'b0};
    vecs[9] = '{1, 4'h0, 4'h0, 3'd3, 4'hF, 1'b0};

    // Reset values, before any clock edge.
    #2;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_result", {28'd0, rsp_result}, 32'd0);
    check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_op_count", {24'd0, op_count}, 32'd0);
    check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);

    // Release at a negedge; the first op must handshake on the next edge.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].rq, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].err);
    end

    // Exhaustive legal-op sweep through requester 1; op_count wraps past 255.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int op = 0; op < 6; op++) begin
          r = ref_op(a[3:0], b[3:0], op[2:0]);
          run_op(1, a[3:0], b[3:0], op[2:0], r[3:0], r[4]);
        end
      end
    end

    // Contention straight after reset: grants alternate 0,1,0,1.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    exp_cnt = 8'd0;
    rsp_ready = 1'b1;
    req0_a = 4'h3; req0_b = 4'h5; req0_op = 3'd0;
    req1_a = 4'h3; req1_b = 4'h5; req1_op = 3'd1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
        #1;
        if (req0_ready || req1_ready) found = 1'b1;
        else @(negedge clk);
      end
      check("cont_found", {31'd0, found}, 32'd1);
      check("cont_grant", {31'd0, req1_ready}, g & 1);
      check("cont_both", {31'd0, req0_ready & req1_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("cont_op_count", {24'd0, op_count}, 32'd4);

    // Backpressure: response held for 5 cycles with a competing requester.
    rsp_ready = 1'b0;
    req0_a = 4'h3; req0_b = 4'h5; req0_op = 3'd1;
    req0_valid = 1'b1;
    #1;
    check("bp_grant0", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req0_a = 4'h0; req0_op = 3'd0;
    req1_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_result", {28'd0, rsp_result}, 32'h7);
      check("bp_rsp_id", {31'd0, rsp_id}, 32'd0);
      check("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      check("bp_op_count", {24'd0, op_count}, 32'd4);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_release_count", {24'd0, op_count}, 32'd5);
    check("bp_idle_grant1", {31'd0, req1_ready}, 32'd1);
    // Requester 1 withdraws before its grant edge: it must not be serviced.
    req1_valid = 1'b0;
    #1;
    check("drop_ready", {31'd0, req1_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("drop_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check("drop_count", {24'd0, op_count}, 32'd5);
      check("drop_hold_result", {28'd0, rsp_result}, 32'h7);
    end

    // Reset in EXEC: aborts, and priority returns to requester 0 even though
    // requester 0 was the last grant.
    req0_a = 4'hF; req0_b = 4'h0; req0_op = 3'd0;
    req0_valid = 1'b1;
    #1;
    check("rm_grant0", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rm_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rm_op_count", {24'd0, op_count}, 32'd0);
    check("rm_rsp_result", {28'd0, rsp_result}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req0_a = 4'hA; req0_b = 4'h5; req0_op = 3'd1;
    req1_a = 4'h1; req1_b = 4'h1; req1_op = 3'd0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rm_cont_ready0", {31'd0, req0_ready}, 32'd1);
    check("rm_cont_ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    check("rm_rsp_valid2", {31'd0, rsp_valid}, 32'd1);
    check("rm_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("rm_rsp_result2", {28'd0, rsp_result}, 32'hF);
    @(posedge clk); #1;
    check("rm_op_count2", {24'd0, op_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
